// File: rtl/norm_shift_pipe.sv
// norm_shift_pipe: two-stage normalize shifter (LZC shift + exponent adjust, zero/underflow flush); fine correction under NORM_FINE_EN
module norm_shift_pipe #(
    parameter int WIDTH = 28,
    parameter int EXP_W = 8,
    localparam int P_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] m_in,
    input  logic [EXP_W-1:0] e_in,
    input  logic [P_W-1:0]   p,
    input  logic             v,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] m_out,
    output logic [EXP_W-1:0] e_out,
    output logic             zero_out,
    output logic             uflow_out
);
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_m_q, s1_m_d;
    logic [EXP_W-1:0] s1_e_q, s1_e_d;
    logic [P_W-1:0]   s1_p_q, s1_p_d;
    logic             s1_v_q, s1_v_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] m_out_q, m_out_d;
    logic [EXP_W-1:0] e_out_q, e_out_d;
    logic             zero_q, zero_d;
    logic             uflow_q, uflow_d;
    logic             s1_take, s2_take, is_zero, is_uflow;
    logic [P_W:0]     sh;
    logic [EXP_W:0]   e_diff;
`ifdef NORM_FINE_EN
    logic [P_W-1:0]   msb_idx;
`endif

    // Handshake: S2 takes from S1 when it is empty or draining; S1 takes input when it can move on
    always_comb begin
        s2_take    = s1_valid_q & (~s2_valid_q | out_ready);
        in_ready   = ~s1_valid_q | ~s2_valid_q | out_ready;
        s1_take    = in_valid & in_ready;
        s1_valid_d = s1_take | (s1_valid_q & ~s2_take);
        s2_valid_d = s2_take | (s2_valid_q & ~out_ready);
        s1_m_d     = s1_take ? m_in : s1_m_q;
        s1_e_d     = s1_take ? e_in : s1_e_q;
        s1_p_d     = s1_take ? p : s1_p_q;
        s1_v_d     = s1_take ? v : s1_v_q;
    end

    // Shift amount, exponent borrow and flush classification for the beat leaving S1
    always_comb begin
`ifdef NORM_FINE_EN
        msb_idx = P_W'(WIDTH - 1) - s1_p_q;
        sh      = {1'b0, s1_p_q} + {{P_W{1'b0}}, s1_v_q & ~s1_m_q[msb_idx]};
`else
        sh      = {1'b0, s1_p_q};
`endif
        e_diff   = {1'b0, s1_e_q} - (EXP_W+1)'(sh);
        is_zero  = ~s1_v_q | ({1'b0, s1_p_q} >= (P_W+1)'(WIDTH));
        is_uflow = ~is_zero & (e_diff[EXP_W] | (e_diff == '0));
        m_out_d  = s2_take ? ((is_zero | is_uflow) ? '0 : s1_m_q << sh) : m_out_q;
        e_out_d  = s2_take ? ((is_zero | is_uflow) ? '0 : e_diff[EXP_W-1:0]) : e_out_q;
        zero_d   = s2_take ? is_zero : zero_q;
        uflow_d  = s2_take ? is_uflow : uflow_q;
    end

    // Pipeline registers; reset discards in-flight beats immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_m_q     <= '0;
            s1_e_q     <= '0;
            s1_p_q     <= '0;
            s1_v_q     <= 1'b0;
            s2_valid_q <= 1'b0;
            m_out_q    <= '0;
            e_out_q    <= '0;
            zero_q     <= 1'b0;
            uflow_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_m_q     <= s1_m_d;
            s1_e_q     <= s1_e_d;
            s1_p_q     <= s1_p_d;
            s1_v_q     <= s1_v_d;
            s2_valid_q <= s2_valid_d;
            m_out_q    <= m_out_d;
            e_out_q    <= e_out_d;
            zero_q     <= zero_d;
            uflow_q    <= uflow_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign m_out     = m_out_q;
    assign e_out     = e_out_q;
    assign zero_out  = zero_q;
    assign uflow_out = uflow_q;
endmodule

// File: tb/tb_norm_shift_pipe.sv
// tb_norm_shift_pipe: directed and random checks of norm_shift_pipe against an arithmetic reference model
module tb_norm_shift_pipe;
    localparam int W = 28;
    localparam int EW = 8;

    typedef struct packed {
        logic [W-1:0]  m;
        logic [EW-1:0] e;
        logic          z;
        logic          u;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  m_in = '0;
    logic [EW-1:0] e_in = '0;
    logic [4:0]    p = '0;
    logic          v = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready, out_valid, zero_out, uflow_out;
    logic [W-1:0]  m_out;
    logic [EW-1:0] e_out;

    int   total = 0;
    int   bad = 0;
    int   n_out = 0;
    logic acc = 1'b0;
    res_t sb[$];
    res_t r;

    norm_shift_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .m_in(m_in), .e_in(e_in),
        .p(p), .v(v), .out_ready(out_ready), .in_ready(in_ready), .out_valid(out_valid),
        .m_out(m_out), .e_out(e_out), .zero_out(zero_out), .uflow_out(uflow_out)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] m, input logic [EW-1:0] e, input int pp, input logic vv);
        res_t   o;
        longint mm = longint'(m);
        int     sh = pp;
        o = '0;
`ifdef NORM_FINE_EN
        if (vv && (((mm << pp) >> (W - 1)) & 1) == 0) sh = pp + 1;
`endif
        if (!vv || pp >= W) o.z = 1'b1;
        else if (sh >= int'(e)) o.u = 1'b1;
        else begin
            o.m = W'((mm << sh) & ((64'd1 << W) - 1));
            o.e = EW'(int'(e) - sh);
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                r = sb.pop_front();
                chk("sb_m", 64'(m_out), 64'(r.m));
                chk("sb_e", 64'(e_out), 64'(r.e));
                chk("sb_zu", {62'd0, zero_out, uflow_out}, {62'd0, r.z, r.u});
                n_out++;
            end
        end
        if (acc) sb.push_back(model(m_in, e_in, int'(p), v));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] m, input logic [EW-1:0] e, input logic [4:0] pp, input logic vv);
        in_valid = 1'b1; m_in = m; e_in = e; p = pp; v = vv;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    logic [W-1:0] saved;
    int           base;

    initial begin
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_data", {27'd0, m_out, e_out, zero_out, uflow_out}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        drive(28'h0AAAAAA, 8'd100, 5'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("basic_lat1", 64'(out_valid), 64'd0);
        tick();
        chk("basic_valid", 64'(out_valid), 64'd1);
        chk("basic_m", 64'(m_out), 64'h0AAAAAA0);
        chk("basic_e", 64'(e_out), 64'd96);
        chk("basic_zu", {62'd0, zero_out, uflow_out}, 64'd0);
        drain();

        drive(28'h1000000, 8'd100, 5'd2, 1'b1);
        tick(); in_valid = 1'b0; tick();
`ifdef NORM_FINE_EN
        chk("odd_m", 64'(m_out), 64'h08000000);
        chk("odd_e", 64'(e_out), 64'd97);
`else
        chk("odd_m", 64'(m_out), 64'h04000000);
        chk("odd_e", 64'(e_out), 64'd98);
`endif
        drain();

        drive(28'h0123456, 8'd50, 5'd4, 1'b0);
        tick(); in_valid = 1'b0; tick();
        chk("zero_flags", {62'd0, zero_out, uflow_out}, 64'd2);
        chk("zero_data", {28'd0, m_out, e_out}, 64'd0);
        drain();

        drive(28'h0AAAAAA, 8'd3, 5'd4, 1'b1);
        tick(); in_valid = 1'b0; tick();
        chk("uflow_flags", {62'd0, zero_out, uflow_out}, 64'd1);
        chk("uflow_data", {28'd0, m_out, e_out}, 64'd0);
        drain();

        base = n_out;
        out_ready = 1'b0;
        drive(28'h0333333, 8'd200, 5'd2, 1'b1);
        tick();
        chk("bp_acc_a", 64'(acc), 64'd1);
        drive(28'h00F0F0F, 8'd150, 5'd4, 1'b1);
        tick();
        chk("bp_acc_b", 64'(acc), 64'd1);
        drive(28'h0000ABC, 8'd120, 5'd16, 1'b1);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        saved = m_out;
        tick(); tick();
        chk("bp_no_acc", 64'(acc), 64'd0);
        chk("bp_hold_m", 64'(m_out), 64'(saved));
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 5 && !acc; i++) tick();
        chk("bp_acc_c", 64'(acc), 64'd1);
        drain();
        chk("bp_count", 64'(n_out - base), 64'd3);

        drive(28'h0555555, 8'd90, 5'd2, 1'b1);
        tick();
        drive(28'h0066666, 8'd80, 5'd6, 1'b1);
        tick();
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_ready", 64'(in_ready), 64'd1);
        chk("rst_mid_data", {27'd0, m_out, e_out, zero_out, uflow_out}, 64'd0);
        sb.delete();
        #1 rst = 1'b0;
        drive(28'h8000001, 8'd10, 5'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("post_rst_lat1", 64'(out_valid), 64'd0);
        tick();
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_m", 64'(m_out), 64'h08000001);
        chk("post_rst_e", 64'(e_out), 64'd10);
        drain();

        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            m_in = W'($urandom);
            e_in = ($urandom_range(0, 3) == 0) ? EW'($urandom_range(0, 8)) : EW'($urandom);
            p = 5'($urandom_range(0, 15) * 2);
            v = 1'($urandom_range(0, 7) != 0);
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
